// File: rtl/ij_input_conditioner.sv
// ij_input_conditioner
// Front end for the two-input control FSM. Each raw asynchronous level
// (i_raw, j_raw) is synchronized, then debounced by a small IDLE/COUNT
// machine. The debounced level is only accepted once it has differed from
// the current output on DEBOUNCE_CYCLES+1 consecutive edges. Registered
// one-cycle rise/fall pulses accompany every accepted change. ij_stable
// reports that neither channel is part-way through a debounce.
module ij_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_raw,
  input  logic j_raw,
  output logic i,
  output logic j,
  output logic i_rise,
  output logic i_fall,
  output logic j_rise,
  output logic j_fall,
  output logic ij_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } ch_state_e;

  // Channel 0 is i, channel 1 is j; both channels use identical logic.
  logic [1:0] raw_s;
  logic [1:0] d_s;
  logic [1:0] rise_s;
  logic [1:0] fall_s;
  logic [1:0] idle_s;

  assign raw_s = {j_raw, i_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    ch_state_e              state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   d_r;
    logic                   rise_r;
    logic                   fall_r;

    // Plain shift-register synchronizer: no logic between the flops.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync_r <= '0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s[ch]};
      end
    end

    assign s_s = sync_r[SYNC_STAGES-1];

    // Debounce machine: the new level must persist for CNT_MAX+1 edges;
    // any return to the current level throws the partial count away.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_r <= ST_IDLE;
        cnt_r   <= '0;
        d_r     <= 1'b0;
        rise_r  <= 1'b0;
        fall_r  <= 1'b0;
      end else begin
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        case (state_r)
          ST_IDLE: begin
            if (s_s != d_r) begin
              state_r <= ST_COUNT;
              cnt_r   <= CNT_ONE;
            end else begin
              cnt_r   <= '0;
            end
          end
          ST_COUNT: begin
            if (s_s == d_r) begin
              state_r <= ST_IDLE;
              cnt_r   <= '0;
            end else if (cnt_r < CNT_MAX) begin
              cnt_r   <= cnt_r + CNT_ONE;
            end else begin
              // Accept the new level; the pulse lands with the new d.
              d_r     <= s_s;
              rise_r  <= s_s;
              fall_r  <= ~s_s;
              state_r <= ST_IDLE;
              cnt_r   <= '0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end
        endcase
      end
    end

    assign d_s[ch]    = d_r;
    assign rise_s[ch] = rise_r;
    assign fall_s[ch] = fall_r;
    assign idle_s[ch] = (state_r == ST_IDLE);
  end

  assign i         = d_s[0];
  assign j         = d_s[1];
  assign i_rise    = rise_s[0];
  assign i_fall    = fall_s[0];
  assign j_rise    = rise_s[1];
  assign j_fall    = fall_s[1];
  assign ij_stable = idle_s[0] & idle_s[1];

endmodule

// File: doc/ij_input_conditioner.md
Name: ij_input_conditioner

Overview:
- Upstream front end for the two-input control FSM.
- Takes two asynchronous raw level inputs (i_raw, j_raw) and produces clean, synchronized, debounced i and j for the FSM's i/j inputs.
- Also produces one-cycle edge pulses and a combined "inputs settled" flag for the bench and any downstream logging.
- Both channels are identical and fully independent.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per channel (legal ≥2).
- DEBOUNCE_CYCLES, 4, extra consecutive samples a new level must persist after first detection (legal ≥1).
- CNT_W, derived localparam = $clog2(DEBOUNCE_CYCLES+1), debounce counter width; not overridable.

Ports:
- clk  input  1  system clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- i_raw  input  1  raw asynchronous level, channel i
- j_raw  input  1  raw asynchronous level, channel j
- i  output  1  debounced level, channel i (registered), drives FSM i
- j  output  1  debounced level, channel j (registered), drives FSM j
- i_rise  output  1  one-cycle pulse, i went 0→1
- i_fall  output  1  one-cycle pulse, i went 1→0
- j_rise  output  1  one-cycle pulse, j went 0→1
- j_fall  output  1  one-cycle pulse, j went 1→0
- ij_stable  output  1  high when both channels are in IDLE (combinational from state)

Behaviour:
- Interface: one clock, clk. Reset rstn is asynchronous, active-low. Reset asserts immediately without waiting for clk; deassertion is sampled on clk.
- Reset values: sync chains all 0, i=j=0, all pulses 0, counters 0, both channels IDLE, ij_stable=1.
- Synchronizer: raw input shifts through SYNC_STAGES flops. The last flop is the synchronized level s. There is no logic between flops.
- Per-channel FSM, states IDLE and COUNT, with debounced register d (= i or j):
  - IDLE, s==d: stay, cnt=0.
  - IDLE, s!=d: go to COUNT, cnt<=1.
  - COUNT, s==d: glitch rejected. Go to IDLE, cnt<=0, d unchanged, no pulse.
  - COUNT, s!=d, cnt<DEBOUNCE_CYCLES: cnt<=cnt+1.
  - COUNT, s!=d, cnt==DEBOUNCE_CYCLES: d<=s, go to IDLE, cnt<=0, fire rise (s=1) or fall (s=0) at the same edge.
- Acceptance rule: s must differ from d on DEBOUNCE_CYCLES+1 consecutive rising edges.
- Latency: for a clean raw change, d updates exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges after the first edge that samples the new raw level. With defaults this is 7.
- Pulses: registered, high for exactly one cycle, coincident with the cycle in which d first shows the new value. Rise and fall of one channel are never high together.
- ij_stable: low whenever either channel is in COUNT.
- Counter never exceeds DEBOUNCE_CYCLES and never wraps.
- Simultaneous events: i and j are independent. Both may enter COUNT, update, and pulse on the same edge.
- Bounce: any return of s to d while in COUNT restarts detection from zero.
- Reset mid-operation: rstn low in any state immediately forces all reset values, including the sync chains. In-progress counts are discarded, no pulse is emitted, and full latency applies after release.
- X-free: outputs are never X after reset, regardless of raw inputs.

Test Plan (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
1. Reset: hold rstn=0 with i_raw=j_raw=1 for 3 cycles → i=j=0, all pulses 0, ij_stable=1. Release with raws held at 1 → i=j=1 on the 7th rising edge after release; i_rise and j_rise each high for exactly 1 cycle.
2. Clean rise: i_raw 0→1 and held, j_raw=0 → i=1 on the 7th edge. ij_stable=0 from the 3rd edge through the 6th edge, 1 again after the 7th. i_rise is 1 cycle; j, j_rise, j_fall stay 0.
3. Glitch: i_raw high for exactly 3 cycles, then low → i stays 0, no i_rise or i_fall, ij_stable returns to 1.
4. Bounce: i_raw toggles 1,0,1,0,1 on successive cycles, then held 1 → i=1 exactly 7 edges after the final 0→1 transition; exactly one i_rise, no i_fall.
5. Simultaneous: i_raw 0→1 and j_raw 0→1 in the same cycle → i and j both go 1 on the same (7th) edge; i_rise and j_rise both high in that cycle. Then both drop together → i_fall and j_fall both high together.
6. Reset mid-count: i_raw 0→1, assert rstn=0 after the 5th edge → i=0 and ij_stable=1 immediately, no pulse. Release with i_raw still 1 → i=1 on the 7th edge after release.
